// File: rtl/motor_drive_supervisor_pkg.sv
// motor_pkg: state encoding and saturating step helper for the motor drive supervisor
package motor_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    RAMP_DOWN = 3'd2,
    DWELL     = 3'd3,
    BRAKE     = 3'd4,
    FAULT     = 3'd5
  } motor_sup_state_t;
  // Steps cur toward tgt by at most step; distances are compared, so nothing can wrap or overshoot
  function automatic logic [31:0] sat_step(input logic [31:0] cur, input logic [31:0] tgt, input logic [31:0] step);
    return cur < tgt ? (tgt - cur <= step ? tgt : cur + step) : (cur - tgt <= step ? tgt : cur - step);
  endfunction
endpackage

// File: rtl/motor_drive_supervisor_if.sv
// motor_drive_supervisor_if: command, parameter and status bundle of the motor drive supervisor
interface motor_drive_supervisor_if #(
  parameter int K_PWMRES = 10,
  parameter int K_SLEW_W = 4,
  parameter int K_TMO_W  = 8
);
  logic                i_tick, i_enable, i_cmd_reverse, i_cmd_brake, i_step, i_fault_clear;
  logic [K_PWMRES-1:0] i_cmd_duty, i_param_pwm_max, i_param_stall_min_duty;
  logic [K_SLEW_W-1:0] i_param_slew;
  logic [K_TMO_W-1:0]  i_param_stall_tmo;
  logic [K_PWMRES-1:0] o_duty;
  logic                o_reverse, o_brake, o_fault, o_at_target;
  logic [2:0]          o_state;
  modport master (
    output i_tick, i_enable, i_cmd_reverse, i_cmd_brake, i_step, i_fault_clear,
    output i_cmd_duty, i_param_pwm_max, i_param_stall_min_duty, i_param_slew, i_param_stall_tmo,
    input  o_duty, o_reverse, o_brake, o_fault, o_at_target, o_state
  );
  modport slave (
    input  i_tick, i_enable, i_cmd_reverse, i_cmd_brake, i_step, i_fault_clear,
    input  i_cmd_duty, i_param_pwm_max, i_param_stall_min_duty, i_param_slew, i_param_stall_tmo,
    output o_duty, o_reverse, o_brake, o_fault, o_at_target, o_state
  );
endinterface

// File: rtl/motor_drive_supervisor_duty_slew_limiter.sv
// duty_slew_limiter: registered duty that moves toward target by step on each tick
module duty_slew_limiter import motor_pkg::*; #(
  parameter int K_PWMRES = 10,
  parameter int K_SLEW_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                force_zero,
  input  logic [K_PWMRES-1:0] target,
  input  logic [K_SLEW_W-1:0] step,
  output logic [K_PWMRES-1:0] duty,
  output logic [K_PWMRES-1:0] duty_nxt
);
  always_comb duty_nxt = force_zero ? '0 : tick ? K_PWMRES'(sat_step(32'(duty), 32'(target), 32'(step))) : duty;
  always_ff @(posedge clk or posedge rst)
    if (rst) duty <= '0;
    else duty <= duty_nxt;
endmodule

// File: rtl/motor_drive_supervisor.sv
// motor_drive_supervisor: slew-limited duty, sequenced reversal, brake and stall fault supervision
module motor_drive_supervisor import motor_pkg::*; #(
  parameter int K_PWMRES      = 10,
  parameter int K_SLEW_W      = 4,
  parameter int K_TMO_W       = 8,
  parameter int K_DWELL_TICKS = 16
) (
  input logic i_clk,
  input logic i_rst,
  motor_drive_supervisor_if.slave bus
);
  localparam int DW = $clog2(K_DWELL_TICKS + 1);
  motor_sup_state_t state, state_n;
  logic [K_PWMRES-1:0] tgt, duty, duty_nxt;
  logic [K_TMO_W-1:0] stall_cnt;
  logic [DW-1:0] dwell_cnt;
  logic rev, brk, flt, at_tgt, rev_req, stalled, flip, ramp, ramp_n;
  assign tgt = bus.i_cmd_duty < bus.i_param_pwm_max ? bus.i_cmd_duty : bus.i_param_pwm_max;
  assign rev_req = bus.i_cmd_reverse != rev;
  assign stalled = state == RUN && bus.i_param_stall_tmo != '0 && stall_cnt == bus.i_param_stall_tmo;
  assign flip = state == DWELL && bus.i_tick && dwell_cnt == DW'(K_DWELL_TICKS - 1);
  assign ramp = state inside {RUN, RAMP_DOWN};
  assign ramp_n = state_n inside {RUN, RAMP_DOWN};
  always_comb begin
    state_n = state;
    if (state == FAULT) state_n = bus.i_fault_clear ? IDLE : FAULT;
    else if (stalled) state_n = FAULT;
    else if (bus.i_cmd_brake) state_n = BRAKE;
    else if (state == BRAKE || !bus.i_enable) state_n = IDLE;
    else case (state)
      IDLE:      state_n = RUN;
      RUN:       state_n = rev_req ? RAMP_DOWN : RUN;
      RAMP_DOWN: state_n = !rev_req ? RUN : duty == '0 ? DWELL : RAMP_DOWN;
      DWELL:     state_n = (!rev_req || flip) ? RUN : DWELL;
      default:   state_n = IDLE;
    endcase
  end
  // Duty only moves while ramping now and next; every other path lands at zero
  duty_slew_limiter #(.K_PWMRES(K_PWMRES), .K_SLEW_W(K_SLEW_W)) u_slew (
    .clk(i_clk), .rst(i_rst), .tick(bus.i_tick), .force_zero(!ramp || !ramp_n),
    .target(state == RAMP_DOWN ? '0 : tgt), .step(bus.i_param_slew),
    .duty(duty), .duty_nxt(duty_nxt)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state     <= IDLE;
      rev       <= 1'b0;
      brk       <= 1'b0;
      flt       <= 1'b0;
      at_tgt    <= 1'b0;
      stall_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_n;
      rev       <= state == IDLE ? bus.i_cmd_reverse : (flip && rev_req && state_n == RUN) ? ~rev : rev;
      brk       <= state_n == BRAKE;
      flt       <= state_n == FAULT;
      at_tgt    <= state_n == RUN && duty_nxt == tgt;
      stall_cnt <= (state != RUN || state_n != RUN || bus.i_step || duty < bus.i_param_stall_min_duty) ? '0 :
                   (bus.i_tick && stall_cnt != '1) ? stall_cnt + K_TMO_W'(1) : stall_cnt;
      dwell_cnt <= (state == DWELL && state_n == DWELL) ? dwell_cnt + DW'(bus.i_tick) : '0;
    end
  assign bus.o_duty      = duty;
  assign bus.o_reverse   = rev;
  assign bus.o_brake     = brk;
  assign bus.o_fault     = flt;
  assign bus.o_at_target = at_tgt;
  assign bus.o_state     = state;
endmodule

// File: tb/tb_motor_drive_supervisor.sv
// tb_motor_drive_supervisor: directed checks of ramping, reversal, brake, stall fault and reset
module tb_motor_drive_supervisor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  motor_drive_supervisor_if #(.K_PWMRES(10), .K_SLEW_W(4), .K_TMO_W(8)) bus ();
  motor_drive_supervisor #(.K_PWMRES(10), .K_SLEW_W(4), .K_TMO_W(8), .K_DWELL_TICKS(16)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic tk();
    bus.i_tick = 1'b1;
    @(negedge clk);
    bus.i_tick = 1'b0;
    @(negedge clk);
  endtask
  task automatic stp();
    bus.i_step = 1'b1;
    @(negedge clk);
    bus.i_step = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(bus.o_state), 0);
    chk({tag, "_duty"}, int'(bus.o_duty), 0);
    chk({tag, "_rev"}, int'(bus.o_reverse), 0);
    chk({tag, "_brake"}, int'(bus.o_brake), 0);
    chk({tag, "_fault"}, int'(bus.o_fault), 0);
    chk({tag, "_at_tgt"}, int'(bus.o_at_target), 0);
  endtask
  initial begin
    bus.i_tick = 0; bus.i_enable = 0; bus.i_cmd_reverse = 0; bus.i_cmd_brake = 0;
    bus.i_step = 0; bus.i_fault_clear = 0; bus.i_cmd_duty = 0;
    bus.i_param_pwm_max = 10'd1000; bus.i_param_slew = 4'd4;
    bus.i_param_stall_tmo = 8'd0; bus.i_param_stall_min_duty = 10'd10;
    cyc(2);
    chk_all_zero("reset");
    rst = 1'b0;
    cyc(1);
    bus.i_cmd_duty = 10'd20; bus.i_enable = 1'b1;
    cyc(1);
    chk("idle_to_run", int'(bus.o_state), 1);
    for (int i = 1; i <= 5; i++) begin
      tk();
      chk("ramp_duty", int'(bus.o_duty), 4 * i);
      chk("ramp_at_tgt", int'(bus.o_at_target), int'(i == 5));
    end
    bus.i_cmd_duty = 10'd1023;
    repeat (250) tk();
    chk("clamp_max", int'(bus.o_duty), 1000);
    chk("clamp_at_tgt", int'(bus.o_at_target), 1);
    bus.i_param_pwm_max = 10'd1023; bus.i_param_slew = 4'd15;
    tk();
    chk("top_step", int'(bus.o_duty), 1015);
    tk();
    chk("top_sat", int'(bus.o_duty), 1023);
    tk();
    chk("top_hold", int'(bus.o_duty), 1023);
    bus.i_enable = 1'b0;
    cyc(1);
    chk("disable_state", int'(bus.o_state), 0);
    chk("disable_duty", int'(bus.o_duty), 0);
    bus.i_enable = 1'b1; bus.i_cmd_duty = 10'd12; bus.i_param_pwm_max = 10'd1000; bus.i_param_slew = 4'd4;
    cyc(1);
    repeat (3) tk();
    chk("ramp12", int'(bus.o_duty), 12);
    bus.i_cmd_duty = 10'd6;
    tk();
    chk("down_step", int'(bus.o_duty), 8);
    tk();
    chk("down_sat", int'(bus.o_duty), 6);
    bus.i_cmd_duty = 10'd12;
    repeat (2) tk();
    chk("back12", int'(bus.o_duty), 12);
    bus.i_cmd_reverse = 1'b1;
    cyc(1);
    chk("rev_rampdown", int'(bus.o_state), 2);
    tk();
    chk("rev_d8", int'(bus.o_duty), 8);
    tk();
    chk("rev_d4", int'(bus.o_duty), 4);
    tk();
    chk("rev_d0", int'(bus.o_duty), 0);
    chk("rev_dwell", int'(bus.o_state), 3);
    repeat (15) tk();
    chk("dwell15_state", int'(bus.o_state), 3);
    chk("dwell15_rev", int'(bus.o_reverse), 0);
    tk();
    chk("dwell16_state", int'(bus.o_state), 1);
    chk("dwell16_rev", int'(bus.o_reverse), 1);
    chk("dwell16_duty", int'(bus.o_duty), 0);
    tk();
    chk("rerun_d4", int'(bus.o_duty), 4);
    repeat (2) tk();
    bus.i_cmd_reverse = 1'b0;
    cyc(1);
    chk("abort_rampdown", int'(bus.o_state), 2);
    repeat (2) tk();
    chk("abort_d4", int'(bus.o_duty), 4);
    bus.i_cmd_reverse = 1'b1;
    cyc(1);
    chk("abort_run", int'(bus.o_state), 1);
    chk("abort_rev", int'(bus.o_reverse), 1);
    repeat (2) tk();
    chk("abort_d12", int'(bus.o_duty), 12);
    chk("abort_at_tgt", int'(bus.o_at_target), 1);
    bus.i_cmd_duty = 10'd40;
    tk();
    chk("pre_brake_d16", int'(bus.o_duty), 16);
    bus.i_cmd_brake = 1'b1;
    cyc(1);
    chk("brake_state", int'(bus.o_state), 4);
    chk("brake_duty", int'(bus.o_duty), 0);
    chk("brake_out", int'(bus.o_brake), 1);
    bus.i_cmd_brake = 1'b0;
    cyc(1);
    chk("unbrake_idle", int'(bus.o_state), 0);
    chk("unbrake_out", int'(bus.o_brake), 0);
    cyc(1);
    chk("unbrake_run", int'(bus.o_state), 1);
    bus.i_cmd_duty = 10'd20;
    repeat (15) tk();
    chk("tmo0_state", int'(bus.o_state), 1);
    chk("tmo0_duty", int'(bus.o_duty), 20);
    stp();
    bus.i_param_stall_tmo = 8'd3;
    for (int i = 0; i < 5; i++) begin
      repeat (2) tk();
      stp();
    end
    chk("steps_no_fault", int'(bus.o_state), 1);
    repeat (2) tk();
    bus.i_tick = 1'b1; bus.i_step = 1'b1;
    cyc(1);
    bus.i_tick = 1'b0; bus.i_step = 1'b0;
    cyc(1);
    repeat (2) tk();
    chk("coincide_clear", int'(bus.o_state), 1);
    tk();
    chk("stall_state", int'(bus.o_state), 5);
    chk("stall_fault", int'(bus.o_fault), 1);
    chk("stall_duty", int'(bus.o_duty), 0);
    chk("stall_brake", int'(bus.o_brake), 0);
    bus.i_cmd_brake = 1'b1; bus.i_enable = 1'b0;
    cyc(2);
    chk("fault_hold", int'(bus.o_state), 5);
    chk("fault_hold_brake", int'(bus.o_brake), 0);
    bus.i_cmd_brake = 1'b0; bus.i_enable = 1'b1; bus.i_param_stall_tmo = 8'd0;
    bus.i_fault_clear = 1'b1;
    cyc(1);
    bus.i_fault_clear = 1'b0;
    chk("clear_idle", int'(bus.o_state), 0);
    chk("clear_fault", int'(bus.o_fault), 0);
    cyc(1);
    chk("clear_run", int'(bus.o_state), 1);
    bus.i_cmd_reverse = 1'b0;
    cyc(2);
    chk("pre_reset_dwell", int'(bus.o_state), 3);
    repeat (2) tk();
    #2 rst = 1'b1;
    cyc(1);
    chk_all_zero("mid_dwell_reset");
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motor_drive_supervisor.md
Name: motor_drive_supervisor

Overview:
Parametrised next-generation drive controller. It sits between the high-level speed/command logic and the PWM generator and pattern generator.
- Turns raw duty, direction and brake commands into a slew-limited duty, a safely sequenced direction and a brake request.
- Sequences reversal as ramp-down, dwell, then flip.
- Detects stalls from encoder step pulses and latches a fault until it is cleared.

Parameters:
K_PWMRES, 10, width of duty values.
K_SLEW_W, 4, width of the per-tick slew step.
K_TMO_W, 8, width of the stall timeout counter (in ticks).
K_DWELL_TICKS, 16, ticks spent at zero duty before the direction flips (>=1).

Ports:
i_clk  in  1  master clock
i_rst  in  1  asynchronous active-high reset
i_tick  in  1  time-base strobe, one cycle wide; paces ramping, dwell and stall counting
i_enable  in  1  drive enable
i_cmd_duty  in  K_PWMRES  requested duty
i_cmd_reverse  in  1  requested direction
i_cmd_brake  in  1  brake request
i_step  in  1  encoder step pulse, one cycle wide
i_fault_clear  in  1  clears a latched fault
i_param_pwm_max  in  K_PWMRES  duty ceiling
i_param_slew  in  K_SLEW_W  duty change per tick; 0 freezes the duty
i_param_stall_tmo  in  K_TMO_W  stall timeout in ticks; 0 disables stall detection
i_param_stall_min_duty  in  K_PWMRES  duty at and above which stall detection is armed
o_duty  out  K_PWMRES  duty sent to the PWM generator
o_reverse  out  1  applied direction
o_brake  out  1  brake to the pattern generator
o_fault  out  1  stall fault latched
o_at_target  out  1  in RUN and o_duty == target
o_state  out  3  current FSM state encoding

Behaviour:
- Reset: state IDLE; o_duty=0, o_reverse=0, o_brake=0, o_fault=0, o_at_target=0; all counters 0.
- Target: target = min(i_cmd_duty, i_param_pwm_max), computed combinationally.
- State priority, evaluated every cycle: FAULT > brake > !enable > normal transitions.
- IDLE:
  - o_duty=0; o_reverse follows i_cmd_reverse, registered.
  - Goes to RUN when i_enable=1 and i_cmd_brake=0.
- RUN, on each i_tick:
  - Duty moves toward target by i_param_slew.
  - Saturates exactly at target, with no overshoot; the target may drop below the current duty.
  - Update is visible the cycle after the tick.
  - No duty change between ticks.
- RUN to RAMP_DOWN: when i_cmd_reverse != o_reverse.
- RAMP_DOWN:
  - Duty decreases by slew per tick toward 0, saturating at 0.
  - Goes to DWELL the cycle after o_duty reaches 0.
  - If i_cmd_reverse returns to o_reverse, goes back to RUN without toggling; the ramp resumes from the current duty.
- DWELL:
  - o_duty=0; counts K_DWELL_TICKS ticks.
  - On the final tick, toggles o_reverse and goes to RUN.
  - If the request reverts, goes to RUN with no toggle.
- BRAKE:
  - Entered from IDLE, RUN, RAMP_DOWN or DWELL when i_cmd_brake=1.
  - o_duty forced to 0 in the same transition; o_brake=1.
  - Goes to IDLE when brake is released.
- Enable low: i_enable=0 in RUN, RAMP_DOWN or DWELL gives IDLE with o_duty=0 on the next cycle.
- Stall counter (RUN only):
  - Cleared on i_step, when o_duty < i_param_stall_min_duty, and on leaving RUN.
  - Otherwise increments on i_tick, saturating.
  - When the counter equals i_param_stall_tmo and tmo != 0, goes to FAULT.
  - If i_step and i_tick coincide, the step wins and the counter clears.
- FAULT:
  - o_duty=0, o_brake=0, o_fault=1.
  - Ignores every input except i_fault_clear, which goes to IDLE next cycle with o_fault=0.
- All outputs are registered; o_state uses the package encoding.
- Arithmetic is done at K_PWMRES+1 bits before clamping, so there is no wrap-around at the duty maximum.

Decomposition:
- motor_pkg holds:
  - enum motor_sup_state_t (3 bits): IDLE=0, RUN=1, RAMP_DOWN=2, DWELL=3, BRAKE=4, FAULT=5.
  - Helper function sat_step(cur, tgt, step) for the saturating toward-target step.
- Sub-module duty_slew_limiter (K_PWMRES, K_SLEW_W):
  - Registered duty.
  - Inputs: tick, target, step, force_zero.
  - Used for both the RUN and RAMP_DOWN ramps (RAMP_DOWN drives target=0).

Test Plan:
- Ramp up: max=1000, slew=4, cmd=20, enable → duty 4, 8, 12, 16, 20 on successive ticks; o_at_target=1 after the 5th tick. Then cmd=1023 → duty clamps at 1000.
- Reversal: duty=12, slew=4, flip i_cmd_reverse → 8, 4, 0, then DWELL; o_reverse toggles on the 16th dwell tick; state returns to RUN and ramps up again.
- Reversal abort: a revert during RAMP_DOWN at duty=4 → RUN, o_reverse unchanged, duty ramps back up to target.
- Brake: brake asserted mid-ramp → next cycle duty=0, o_brake=1, state BRAKE. Release → IDLE, then RUN.
- Stall: tmo=3, min_duty=10, duty=20, no i_step → FAULT after the 3rd tick with o_fault=1, duty=0. A step pulse every 2 ticks → never faults. A step coincident with a tick → counter clears.
- Reset mid-DWELL → all outputs 0, state IDLE. Fault clear → IDLE. tmo=0 → never faults.
